data_mem_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the data memory interface (user .data and system .kdata blocks). It shares one memory bus between port 0 (CPU load/store unit) and port 1 (secondary master: debug/DMA/display reader). It latches one request at a time and drives the memory read/write strobes, byte enables, address and write data with fixed timing. It returns read data and a one-cycle acknowledge to the winning port. Address decode stays downstream; the arbiter passes addresses through unmodified.

---
 rtl/data_arb_pkg.sv | 17 +
 rtl/data_mem_arbiter_rr_picker2.sv | 41 ++++
 rtl/data_mem_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_arb_pkg.sv
// Shared types and constants for the data memory arbiter.
package data_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  // Wide enough for the largest supported memory latency (7).
  localparam int unsigned CNT_W = 3;

endpackage

// File: rtl/data_mem_arbiter_rr_picker2.sv
// Two-way round-robin picker. The pointer names the preferred port and
// flips only when both ports contend in an open arbitration slot.
module rr_picker2
  import data_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic       valid,
  output logic       winner
);

  logic ptr_q, ptr_d;

  // Pick a winner and compute the next pointer value.
  always_comb begin
    valid  = |req;
    winner = PORT_CPU;
    ptr_d  = ptr_q;
    unique case (req)
      2'b01:   winner = PORT_CPU;
      2'b10:   winner = PORT_AUX;
      2'b11:   winner = ptr_q;
      default: winner = PORT_CPU;
    endcase
    if (grant_en && (&req)) begin
      ptr_d = ~ptr_q;
    end
  end

  // Pointer register; port 0 preferred out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= PORT_CPU;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter/sequencer in front of the data memory interface.
// Optional feature macro: DATA_ARB_LOCK_EN adds iLock0/iLock1 so a port can
// hold the bus across several transactions (atomic read-modify-write).
module data_mem_arbiter
  import data_arb_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32
) (
  input  logic                iCLK,
  input  logic                iRST,
`ifdef DATA_ARB_LOCK_EN
  input  logic                iLock0,
  input  logic                iLock1,
`endif
  input  logic                iReq0,
  input  logic                iReq1,
  input  logic                iWe0,
  input  logic                iWe1,
  input  logic [DATA_W/8-1:0] iBe0,
  input  logic [DATA_W/8-1:0] iBe1,
  input  logic [ADDR_W-1:0]   iAddr0,
  input  logic [ADDR_W-1:0]   iAddr1,
  input  logic [DATA_W-1:0]   iWData0,
  input  logic [DATA_W-1:0]   iWData1,
  output logic                oAck0,
  output logic                oAck1,
  output logic [DATA_W-1:0]   oRData0,
  output logic [DATA_W-1:0]   oRData1,
  output logic                oMemRE,
  output logic                oMemWE,
  output logic [DATA_W/8-1:0] oMemBE,
  output logic [ADDR_W-1:0]   oMemAddr,
  output logic [DATA_W-1:0]   oMemWData,
  input  logic [DATA_W-1:0]   iMemRData,
  output logic                oBusy
);

  localparam int unsigned BE_W = DATA_W / 8;

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              win_q, win_d;
  logic              we_q, we_d;
  logic              mem_re_q, mem_re_d;
  logic              mem_we_q, mem_we_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              busy_q, busy_d;

  logic [1:0]        req_elig;
  logic              grant_en;
  logic              pick_valid;
  logic              pick_win;
  logic              sel_we;

`ifdef DATA_ARB_LOCK_EN
  logic lock_q, lock_d;
  logic lock_port_q, lock_port_d;

  // While a lock is held only the holder takes part in arbitration.
  always_comb begin
    req_elig = {iReq1, iReq0};
    if (lock_q) begin
      req_elig = (lock_port_q == PORT_AUX) ? {iReq1, 1'b0} : {1'b0, iReq0};
    end
  end
`else
  // Both ports always eligible.
  always_comb begin
    req_elig = {iReq1, iReq0};
  end
`endif

  assign grant_en = (state_q == IDLE);
  assign sel_we   = (pick_win == PORT_AUX) ? iWe1 : iWe0;

  rr_picker2 u_picker (
    .clk      (iCLK),
    .rst      (iRST),
    .req      (req_elig),
    .grant_en (grant_en),
    .valid    (pick_valid),
    .winner   (pick_win)
  );

  // Next-state and next-output logic; outputs are registered so each value
  // computed here is what the bus sees during the state being entered.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    win_d       = win_q;
    we_d        = we_q;
    mem_re_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
`ifdef DATA_ARB_LOCK_EN
    lock_d      = lock_q;
    lock_port_d = lock_port_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d     = ISSUE;
          win_d       = pick_win;
          we_d        = sel_we;
          mem_we_d    = sel_we;
          mem_re_d    = ~sel_we;
          mem_be_d    = (pick_win == PORT_AUX) ? iBe1    : iBe0;
          mem_addr_d  = (pick_win == PORT_AUX) ? iAddr1  : iAddr0;
          mem_wdata_d = (pick_win == PORT_AUX) ? iWData1 : iWData0;
        end
      end
      ISSUE: begin
        state_d  = WAIT;
        cnt_d    = CNT_W'(MEM_LATENCY);
        mem_re_d = ~we_q;
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d     = DONE;
          ack0_d      = (win_q == PORT_CPU);
          ack1_d      = (win_q == PORT_AUX);
          mem_be_d    = '0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          if (!we_q) begin
            if (win_q == PORT_AUX) begin
              rdata1_d = iMemRData;
            end else begin
              rdata0_d = iMemRData;
            end
          end
        end else begin
          mem_re_d = ~we_q;
        end
      end
      DONE: begin
        state_d = IDLE;
`ifdef DATA_ARB_LOCK_EN
        lock_d      = (win_q == PORT_AUX) ? iLock1 : iLock0;
        lock_port_d = win_q;
`endif
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, latched transaction and registered outputs.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      win_q       <= PORT_CPU;
      we_q        <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      busy_q      <= 1'b0;
`ifdef DATA_ARB_LOCK_EN
      lock_q      <= 1'b0;
      lock_port_q <= PORT_CPU;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      win_q       <= win_d;
      we_q        <= we_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      busy_q      <= busy_d;
`ifdef DATA_ARB_LOCK_EN
      lock_q      <= lock_d;
      lock_port_q <= lock_port_d;
`endif
    end
  end

  assign oAck0     = ack0_q;
  assign oAck1     = ack1_q;
  assign oRData0   = rdata0_q;
  assign oRData1   = rdata1_q;
  assign oMemRE    = mem_re_q;
  assign oMemWE    = mem_we_q;
  assign oMemBE    = mem_be_q;
  assign oMemAddr  = mem_addr_q;
  assign oMemWData = mem_wdata_q;
  assign oBusy     = busy_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed scenarios plus random
// two-port traffic against a transaction-timing reference model, and a
// second instance with MEM_LATENCY = 3.
module tb_data_mem_arbiter;

  localparam int LAT  = 1;
  localparam int LAT3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- main instance (MEM_LATENCY = 1) ----------------
  logic        rst;
  logic [1:0]  req, we, lk;
  logic [3:0]  be   [2];
  logic [31:0] addr [2];
  logic [31:0] wd   [2];
  logic        ack0, ack1, mre, mwe, busy;
  logic [31:0] rd0, rd1, maddr, mwd, memr;
  logic [3:0]  mbe;

  data_mem_arbiter #(.MEM_LATENCY(LAT), .ADDR_W(32), .DATA_W(32)) u_dut (
    .iCLK(clk), .iRST(rst),
`ifdef DATA_ARB_LOCK_EN
    .iLock0(lk[0]), .iLock1(lk[1]),
`endif
    .iReq0(req[0]), .iReq1(req[1]), .iWe0(we[0]), .iWe1(we[1]),
    .iBe0(be[0]), .iBe1(be[1]), .iAddr0(addr[0]), .iAddr1(addr[1]),
    .iWData0(wd[0]), .iWData1(wd[1]), .oAck0(ack0), .oAck1(ack1),
    .oRData0(rd0), .oRData1(rd1), .oMemRE(mre), .oMemWE(mwe), .oMemBE(mbe),
    .oMemAddr(maddr), .oMemWData(mwd), .iMemRData(memr), .oBusy(busy)
  );

  // Reference model: a transaction started (request seen) in cycle s issues
  // in s+1, holds the bus through s+1+LAT, acks in s+2+LAT, and the bus is
  // free for a new request in s+3+LAT.
  int          cyc    = 0;
  int          m_s    = 0;
  logic        m_busy = 1'b0;
  logic        m_w    = 1'b0;
  logic        m_we   = 1'b0;
  logic [3:0]  m_be   = '0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wd   = '0;
  logic [31:0] m_rd0  = '0;
  logic [31:0] m_rd1  = '0;
  logic        m_ptr  = 1'b0;
  logic        m_lock = 1'b0;
  logic        m_lport = 1'b0;
  logic        chk_en = 1'b0;
  logic [1:0]  m_elig;
  logic        m_pick;

  assign m_elig = {req[1] && !(m_lock && !m_lport), req[0] && !(m_lock && m_lport)};
  assign m_pick = (m_elig == 2'b11) ? m_ptr : m_elig[1];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_busy <= 1'b0;
      m_ptr  <= 1'b0;
      m_rd0  <= '0;
      m_rd1  <= '0;
      m_lock <= 1'b0;
    end else if (m_busy) begin
      if (cyc == m_s + 1 + LAT && !m_we) begin
        if (m_w) m_rd1 <= memr;
        else     m_rd0 <= memr;
      end
      if (cyc == m_s + 2 + LAT) begin
        m_busy  <= 1'b0;
        m_lock  <= m_w ? lk[1] : lk[0];
        m_lport <= m_w;
      end
    end else if (m_elig != 2'b00) begin
      m_busy <= 1'b1;
      m_s    <= cyc;
      m_w    <= m_pick;
      m_we   <= we[m_pick];
      m_be   <= be[m_pick];
      m_addr <= addr[m_pick];
      m_wd   <= wd[m_pick];
      if (m_elig == 2'b11) m_ptr <= ~m_ptr;
    end
  end

  logic e_tx, e_re, e_we, e_ack0, e_ack1;
  assign e_tx   = m_busy && (cyc >= m_s + 1) && (cyc <= m_s + 1 + LAT);
  assign e_re   = e_tx && !m_we;
  assign e_we   = m_busy && (cyc == m_s + 1) && m_we;
  assign e_ack0 = m_busy && (cyc == m_s + 2 + LAT) && !m_w;
  assign e_ack1 = m_busy && (cyc == m_s + 2 + LAT) && m_w;

  always @(negedge clk) begin
    if (chk_en) begin
      check("bus_ctl", {mre, mwe, mbe, busy, ack1, ack0},
            {e_re, e_we, (e_tx ? m_be : 4'b0), m_busy, e_ack1, e_ack0});
      check("bus_addr", maddr, e_tx ? m_addr : 32'h0);
      check("bus_wdata", mwd, e_tx ? m_wd : 32'h0);
      check("rdata0", rd0, m_rd0);
      check("rdata1", rd1, m_rd1);
    end
  end

  // Watch the main DUT for ncyc cycles starting in cycle 0 of a request;
  // each port drops its request at the edge where it sees its ack.
  task automatic run_watch(input int ncyc, output int a0_at, output int a1_at,
                           output int re_first, output int re_cnt, output int we_cnt,
                           output logic [31:0] w_addr, output logic [3:0] w_be,
                           output logic [31:0] w_wd);
    logic g0, g1;
    a0_at = -1; a1_at = -1; re_first = -1; re_cnt = 0; we_cnt = 0;
    w_addr = '0; w_be = '0; w_wd = '0;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      if (mre) begin
        re_cnt++;
        if (re_first < 0) re_first = k;
      end
      if (mwe) begin
        we_cnt++;
        w_addr = maddr; w_be = mbe; w_wd = mwd;
      end
      g0 = ack0; g1 = ack1;
      if (g0 && a0_at < 0) a0_at = k;
      if (g1 && a1_at < 0) a1_at = k;
      @(posedge clk); #1;
      if (g0) req[0] = 1'b0;
      if (g1) req[1] = 1'b0;
    end
  endtask

  // ---------------- second instance (MEM_LATENCY = 3) ----------------
  logic        rst3;
  logic [1:0]  req3, we3, lk3;
  logic [3:0]  be3   [2];
  logic [31:0] addr3 [2];
  logic [31:0] wd3   [2];
  logic [1:0]  ack3;
  logic        m3re, m3we, busy3;
  logic [31:0] rd3 [2];
  logic [31:0] m3addr, m3wd, memr3;
  logic [3:0]  m3be;

  data_mem_arbiter #(.MEM_LATENCY(LAT3), .ADDR_W(32), .DATA_W(32)) u_dut3 (
    .iCLK(clk), .iRST(rst3),
`ifdef DATA_ARB_LOCK_EN
    .iLock0(lk3[0]), .iLock1(lk3[1]),
`endif
    .iReq0(req3[0]), .iReq1(req3[1]), .iWe0(we3[0]), .iWe1(we3[1]),
    .iBe0(be3[0]), .iBe1(be3[1]), .iAddr0(addr3[0]), .iAddr1(addr3[1]),
    .iWData0(wd3[0]), .iWData1(wd3[1]), .oAck0(ack3[0]), .oAck1(ack3[1]),
    .oRData0(rd3[0]), .oRData1(rd3[1]), .oMemRE(m3re), .oMemWE(m3we), .oMemBE(m3be),
    .oMemAddr(m3addr), .oMemWData(m3wd), .iMemRData(memr3), .oBusy(busy3)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = '0; we = '0; lk = '0; memr = '0;
    rst3 = 1'b1; req3 = '0; we3 = '0; lk3 = '0; memr3 = '0;
    for (int p = 0; p < 2; p++) begin
      be[p] = '0; addr[p] = '0; wd[p] = '0;
      be3[p] = '0; addr3[p] = '0; wd3[p] = '0;
    end
    fork
      begin : main_seq
        int a0, a1, rf, rc, wc;
        logic [31:0] wa, wdd;
        logic [3:0]  wb;
        logic [1:0]  a;
        @(posedge clk); #1 chk_en = 1'b1;
        @(posedge clk); #1 rst = 1'b0;

        // Single CPU read.
        memr = 32'hDEADBEEF; we[0] = 1'b0; be[0] = 4'hF; addr[0] = 32'h1001_0000; req[0] = 1'b1;
        run_watch(8, a0, a1, rf, rc, wc, wa, wb, wdd);
        check("d1_ack0_cycle", a0, 3);
        check("d1_ack1_never", a1, -1);
        check("d1_re_first", rf, 1);
        check("d1_re_cycles", rc, 2);
        check("d1_rdata0", rd0, 32'hDEADBEEF);

        // Single port-1 write.
        memr = 32'h1234_5678; we[1] = 1'b1; be[1] = 4'b0011;
        addr[1] = 32'h1001_0004; wd[1] = 32'h0000_ABCD; req[1] = 1'b1;
        run_watch(8, a0, a1, rf, rc, wc, wa, wb, wdd);
        check("d2_we_cycles", wc, 1);
        check("d2_we_addr", wa, 32'h1001_0004);
        check("d2_we_be", wb, 4'b0011);
        check("d2_we_data", wdd, 32'h0000_ABCD);
        check("d2_re_cycles", rc, 0);
        check("d2_ack1_cycle", a1, 3);
        check("d2_rdata1_kept", rd1, 32'h0);
        check("d2_rdata0_kept", rd0, 32'hDEADBEEF);

        // Simultaneous requests from reset, twice.
        rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
        memr = 32'hCAFE_0001; we = 2'b00; addr[0] = 32'h100; addr[1] = 32'h200; req = 2'b11;
        run_watch(10, a0, a1, rf, rc, wc, wa, wb, wdd);
        check("d3_ack0_cycle", a0, 3);
        check("d3_ack1_cycle", a1, 7);
        req = 2'b11;
        run_watch(10, a0, a1, rf, rc, wc, wa, wb, wdd);
        check("d3b_ack1_cycle", a1, 3);
        check("d3b_ack0_cycle", a0, 7);

        // Reset during WAIT.
        memr = 32'h5555_AAAA; we[0] = 1'b0; addr[0] = 32'h300; req[0] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; req[0] = 1'b0;
        @(negedge clk);
        check("d4_ctl_zero", {ack0, ack1, mre, mwe, busy, mbe}, 0);
        check("d4_addr_zero", maddr, 0);
        check("d4_wdata_zero", mwd, 0);
        check("d4_rdata_zero", {rd0, rd1}, 0);
        @(posedge clk); #1 req[0] = 1'b1;
        run_watch(8, a0, a1, rf, rc, wc, wa, wb, wdd);
        check("d4_after_ack0", a0, 3);
        check("d4_after_rdata0", rd0, 32'h5555_AAAA);

`ifdef DATA_ARB_LOCK_EN
        begin : lock_test
          int n0, first0, second0, first1;
          logic g0, g1;
          rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
          we = 2'b00; lk = 2'b01; addr[0] = 32'h400; addr[1] = 32'h500; req = 2'b11;
          n0 = 0; first0 = -1; second0 = -1; first1 = -1;
          for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            g0 = ack0; g1 = ack1;
            if (g0) begin
              if (n0 == 0) first0 = k;
              else if (n0 == 1) second0 = k;
              n0++;
            end
            if (g1 && first1 < 0) first1 = k;
            @(posedge clk); #1;
            if (g0 && n0 == 1) begin
              we[0] = 1'b1; lk[0] = 1'b0; wd[0] = 32'h0BAD_F00D;
            end else if (g0) begin
              req[0] = 1'b0;
            end
            if (g1) req[1] = 1'b0;
          end
          check("lock_rd_ack", first0, 3);
          check("lock_wr_ack", second0, 7);
          check("lock_aux_ack", first1, 11);
        end
`endif

        // Random two-port traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
          @(negedge clk); a = {ack1, ack0};
          @(posedge clk); #1;
          rst  = ($urandom_range(0, 99) == 0);
          memr = $urandom;
          for (int p = 0; p < 2; p++) begin
            if (req[p] && a[p]) req[p] = ($urandom_range(0, 2) == 0);
            else if (!req[p])   req[p] = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) begin
              we[p] = 1'($urandom_range(0, 1)); be[p] = 4'($urandom);
              addr[p] = $urandom; wd[p] = $urandom;
            end
`ifdef DATA_ARB_LOCK_EN
            lk[p] = ($urandom_range(0, 2) == 0);
`endif
          end
        end
        rst = 1'b0; req = '0;
        repeat (8) @(posedge clk);
      end

      begin : lat3_seq
        logic [31:0] mv [10];
        logic [31:0] exp_rd [2];
        logic [9:0]  re_m, we_m;
        logic [31:0] a3;
        int p, ack_at, other, addr_bad;
        logic w, g, go;
        @(posedge clk); #1;
        @(posedge clk); #1 rst3 = 1'b0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        for (int t = 0; t < 8; t++) begin
          p = $urandom_range(0, 1);
          w = 1'($urandom_range(0, 1));
          a3 = $urandom;
          we3[p] = w; be3[p] = 4'hF; addr3[p] = a3; wd3[p] = $urandom; req3[p] = 1'b1;
          ack_at = -1; other = 0; addr_bad = 0; re_m = '0; we_m = '0;
          for (int k = 0; k < 10; k++) begin
            mv[k] = $urandom;
            memr3 = mv[k];
            @(negedge clk);
            re_m[k] = m3re;
            we_m[k] = m3we;
            if ((k >= 1 && k <= 4) ? (m3addr !== a3) : (m3addr !== 32'h0)) addr_bad++;
            g  = ack3[p];
            go = ack3[1 - p];
            if (g && ack_at < 0) ack_at = k;
            if (go) other++;
            @(posedge clk); #1;
            if (g) req3[p] = 1'b0;
          end
          if (!w) exp_rd[p] = mv[4];
          check("l3_ack_cycle", ack_at, 5);
          check("l3_ack_other", other, 0);
          check("l3_re_cycles", re_m, w ? 10'b0 : 10'b00_0001_1110);
          check("l3_we_cycles", we_m, w ? 10'b00_0000_0010 : 10'b0);
          check("l3_addr", addr_bad, 0);
          check("l3_rdata0", rd3[0], exp_rd[0]);
          check("l3_rdata1", rd3[1], exp_rd[1]);
        end
      end
    join
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
